image_stream_reader: RTL and testbench
======================================

Name: image_stream_reader

Overview:
Read side of the 28x28 binary image buffer. On a start request, captures the full 784-pixel image into a shadow register and releases the buffer for refill. Then streams the pixels, in write order, as WORD_W-bit beats over a valid/ready interface to the BNN input layer. Sits between the image buffer and the first inference stage.

Parameters:
TOTAL_PIXELS, 784, pixels per image (28x28); pixel index p = row*28 + col, matching buffer write order.
WORD_W, 8, pixels per output beat. Must divide TOTAL_PIXELS; otherwise $fatal at elaboration.
BEATS, TOTAL_PIXELS/WORD_W (localparam), beats per image (98 at default).

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high, one clock domain (clk)
img_bits  in  TOTAL_PIXELS  image from buffer; bit p = pixel p
img_full  in  1  buffer holds a complete image
start  in  1  request to stream the current image
abort  in  1  cancel an in-progress stream
clear_req  out  1  one-cycle pulse; drives the buffer's clear input
out_data  out  WORD_W  beat payload; bit k = pixel (beat*WORD_W + k)
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
out_last  out  1  marks final beat (beat == BEATS-1)
busy  out  1  high in CAPTURE/STREAM
done  out  1  one-cycle pulse after last beat accepted
err_start  out  1  one-cycle pulse: start while !img_full in IDLE
beat_idx  out  $clog2(BEATS)  current beat index (debug)

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; shadow=0; beat_idx=0; all outputs 0. rst has priority over start and abort. Mid-stream reset drops the stream with no done.
- FSM states: IDLE, CAPTURE, STREAM.
- IDLE, start && img_full: shadow <= img_bits; beat_idx <= 0; go CAPTURE.
- IDLE, start && !img_full: err_start pulses for 1 cycle; stay IDLE.
- CAPTURE (exactly 1 cycle): clear_req=1; go STREAM. If start is accepted at edge T, clear_req is high during cycle T+1 and out_valid rises at edge T+2.
- STREAM: out_valid=1.
  - out_data = shadow[beat_idx*WORD_W +: WORD_W].
  - out_last = (beat_idx == BEATS-1).
  - Transfer = out_valid && out_ready at a posedge.
  - On a non-final transfer: beat_idx++.
  - On the final transfer: done=1 next cycle; beat_idx <= 0; go IDLE; out_valid drops in that same next cycle.
- Stall rule: while out_valid && !out_ready, out_data, out_last and beat_idx hold stable. out_valid never drops without a transfer, except on abort or rst.
- abort in CAPTURE or STREAM: go IDLE next cycle; out_valid=0; no done; beat_idx <= 0. clear_req still pulses if abort coincides with CAPTURE (the buffer is already released). abort in IDLE has no effect.
- start while busy is ignored (no error pulse).
- The shadow register decouples the stream from the buffer: img_bits/img_full changes during STREAM have no effect.
- busy = (state != IDLE). done, clear_req and err_start are never high for more than 1 consecutive cycle.
- beat_idx width: $clog2(BEATS), with a minimum of 1. Wrap to 0 happens only on the final transfer; no overflow is possible.
- Back-to-back: start may be accepted in the cycle where done is high. Min gap between images = 1 IDLE cycle + 1 CAPTURE cycle.
- Assertions (sim only):
  - beat_idx < BEATS.
  - out_data stable during a stall.
  - clear_req only in CAPTURE.

Test Plan:
1. Reset, then img_full=1, img_bits with only pixel 0 and pixel 783 set, start pulse, out_ready=1 -> clear_req at T+1. Then 98 beats: beat0 = 8'h01, beats 1-96 = 8'h00, beat97 = 8'h80 with out_last=1. done pulse 1 cycle after beat97.
2. Same image, out_ready toggling 1-0-1 with random 3-cycle stalls -> all 98 beats received in order, payload stable across each stall, total beats = 98 exactly.
3. start with img_full=0 -> err_start=1 for 1 cycle, busy stays 0, no clear_req, out_valid stays 0.
4. Change img_bits to all-ones at beat 10 of a stream of an all-zeros image -> every beat = 8'h00.
5. abort at beat 50 -> out_valid=0 next cycle, no done, busy=0. A new start then streams from beat 0.
6. Assert rst at beat 30 -> same cycle edge: all outputs 0, state IDLE. WORD_W=16 rerun of scenario 1 -> 49 beats, beat48 = 16'h8000 with out_last.

Source files
------------

// File: rtl/image_stream_reader_if.sv
// Beat stream from the image reader to the BNN input layer.
// Rev 1.0
`default_nettype none

interface image_stream_reader_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/image_stream_reader.sv
// +--------------------------------------------------------------------+
// | image_stream_reader: snapshots the 28x28 image, releases the buffer |
// | and streams WORD_W-pixel beats downstream.            Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module image_stream_reader #(
   parameter  int TOTAL_PIXELS = 784,
   parameter  int WORD_W       = 8,
   localparam int BEATS        = TOTAL_PIXELS / WORD_W,
   localparam int IDX_W        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [TOTAL_PIXELS-1:0] img_bits_i,
   input  logic                    img_full_i,
   input  logic                    start_i,
   input  logic                    abort_i,
   output logic                    clear_req_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_start_o,
   output logic [IDX_W-1:0]        beat_idx_o,
   image_stream_reader_if.master   out_if
);

   if ((TOTAL_PIXELS % WORD_W) != 0) begin : g_bad_word_w
      $fatal(1, "image_stream_reader: WORD_W must divide TOTAL_PIXELS");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_STREAM  = 2'd2
   } state_t;

   state_t                         state_q;
   logic [BEATS-1:0][WORD_W-1:0]   shadow_q;
   logic [IDX_W-1:0]               beat_idx_q;
   logic                           out_valid_q;
   logic                           clear_req_q;
   logic                           done_q;
   logic                           err_start_q;
   logic                           w_xfer;

   assign w_xfer = out_valid_q && out_if.out_ready;

   // Shadow is viewed as an array of beats so the payload mux is a plain index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shadow_q    <= '0;
         beat_idx_q  <= '0;
         out_valid_q <= 1'b0;
         clear_req_q <= 1'b0;
         done_q      <= 1'b0;
         err_start_q <= 1'b0;
      end else begin
         clear_req_q <= 1'b0;
         done_q      <= 1'b0;
         err_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (img_full_i) begin
                     shadow_q    <= img_bits_i;
                     beat_idx_q  <= '0;
                     clear_req_q <= 1'b1;
                     state_q     <= S_CAPTURE;
                  end else begin
                     err_start_q <= 1'b1;
                  end
               end
            end
            S_CAPTURE: begin
               beat_idx_q <= '0;
               if (abort_i) begin
                  state_q <= S_IDLE;
               end else begin
                  state_q     <= S_STREAM;
                  out_valid_q <= 1'b1;
               end
            end
            S_STREAM: begin
               if (abort_i) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  beat_idx_q  <= '0;
               end else if (w_xfer) begin
                  if (beat_idx_q == LAST_IDX) begin
                     state_q     <= S_IDLE;
                     out_valid_q <= 1'b0;
                     beat_idx_q  <= '0;
                     done_q      <= 1'b1;
                  end else begin
                     beat_idx_q <= beat_idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
               beat_idx_q  <= '0;
            end
         endcase
      end
   end

   assign out_if.out_data  = out_valid_q ? shadow_q[beat_idx_q] : '0;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_last  = out_valid_q && (beat_idx_q == LAST_IDX);
   assign clear_req_o      = clear_req_q;
   assign busy_o           = (state_q != S_IDLE);
   assign done_o           = done_q;
   assign err_start_o      = err_start_q;
   assign beat_idx_o       = beat_idx_q;

`ifndef SYNTHESIS
   logic              chk_stall_q;
   logic [WORD_W-1:0] chk_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_stall_q <= 1'b0;
         chk_data_q  <= '0;
      end else begin
         chk_stall_q <= out_valid_q && !out_if.out_ready && !abort_i;
         chk_data_q  <= out_if.out_data;
         assert (int'(beat_idx_q) < BEATS)
            else $error("beat_idx out of range");
         assert (!(chk_stall_q && out_valid_q) || (out_if.out_data == chk_data_q))
            else $error("out_data changed during stall");
         assert (!clear_req_q || (state_q == S_CAPTURE))
            else $error("clear_req outside CAPTURE");
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_image_stream_reader.sv
// Directed + randomized bench for image_stream_reader at WORD_W=8 and WORD_W=16.
// Rev 1.0
`default_nettype none

module tb_image_stream_reader;
   localparam int TP      = 784;
   localparam int BEATS8  = TP / 8;
   localparam int BEATS16 = TP / 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [TP-1:0] img_bits, img16;
   logic          img_full, start, abort;
   logic          full16, start16;
   logic          clear_req, busy, done, err_start;
   logic          clr16, busy16, done16, err16;
   logic [6:0]    beat_idx;
   logic [5:0]    idx16;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   image_stream_reader_if #(.WORD_W(8))  if8  ();
   image_stream_reader_if #(.WORD_W(16)) if16 ();

   image_stream_reader #(.TOTAL_PIXELS(TP), .WORD_W(8)) dut (
      .clk(clk), .rst(rst), .img_bits_i(img_bits), .img_full_i(img_full),
      .start_i(start), .abort_i(abort), .clear_req_o(clear_req), .busy_o(busy),
      .done_o(done), .err_start_o(err_start), .beat_idx_o(beat_idx), .out_if(if8)
   );

   image_stream_reader #(.TOTAL_PIXELS(TP), .WORD_W(16)) dut16 (
      .clk(clk), .rst(rst), .img_bits_i(img16), .img_full_i(full16),
      .start_i(start16), .abort_i(1'b0), .clear_req_o(clr16), .busy_o(busy16),
      .done_o(done16), .err_start_o(err16), .beat_idx_o(idx16), .out_if(if16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: beat b of an image is simply pixels [b*w, b*w+w) in index order.
   function automatic logic [15:0] beat_of(input logic [TP-1:0] img, input int b, input int w);
      logic [TP-1:0] s;
      s = img >> (b * w);
      return (w == 8) ? {8'h00, s[7:0]} : s[15:0];
   endfunction

   function automatic logic [TP-1:0] rand_img();
      logic [TP-1:0] r;
      for (int p = 0; p < TP; p++) r[p] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   task automatic start8(input logic [TP-1:0] img);
      img_bits = img;
      img_full = 1'b1;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("capture_clear_req", clear_req, 1);
      check("capture_busy", busy, 1);
      check("capture_valid", if8.out_valid, 0);
      check("capture_last", if8.out_last, 0);
   endtask

   // Entered at a negedge with the stream visible; leaves at the negedge after
   // the final transfer, or at beat stop_at with out_ready parked low.
   task automatic run_stream(input logic [TP-1:0] img, input bit rnd, input int k0,
                             input int stop_at, output int got);
      int k = k0;
      int budget = 0;
      int stall_left = 0;
      logic rdy;
      while (k < BEATS8 && k != stop_at && budget < 2000) begin
         check("valid", if8.out_valid, 1);
         check("beat_idx", beat_idx, k);
         check("data", if8.out_data, beat_of(img, k, 8));
         check("last", if8.out_last, (k == BEATS8 - 1));
         if (rnd && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else if (rnd && $urandom_range(0, 3) == 0) begin
            rdy = 1'b0;
            stall_left = 2;
         end else begin
            rdy = 1'b1;
         end
         if8.out_ready = rdy;
         if (rdy) k++;
         @(negedge clk);
         budget++;
      end
      got = k;
      if (budget >= 2000) check("stream_timeout", k, BEATS8);
      if (k == stop_at) begin
         if8.out_ready = 1'b0;
      end else begin
         check("done_pulse", done, 1);
         check("post_valid", if8.out_valid, 0);
         check("post_busy", busy, 0);
         check("post_idx", beat_idx, 0);
      end
   endtask

   initial begin
      logic [TP-1:0] img_a, img_z, img_r;
      int got;

      rst = 1'b1; img_bits = '0; img_full = 1'b0; start = 1'b0; abort = 1'b0;
      img16 = '0; full16 = 1'b0; start16 = 1'b0;
      if8.out_ready = 1'b0; if16.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", if8.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_idx", beat_idx, 0);
      check("rst_data", if8.out_data, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);

      // Pixel 0 and pixel 783 only, always-ready sink
      img_a = '0; img_a[0] = 1'b1; img_a[TP-1] = 1'b1;
      if8.out_ready = 1'b1;
      start8(img_a);
      @(negedge clk);
      run_stream(img_a, 1'b0, 0, -1, got);
      // Back-to-back: start in the done cycle, then random stalls
      start8(img_a);
      @(negedge clk);
      run_stream(img_a, 1'b1, 0, -1, got);
      check("beat_count", got, BEATS8);
      @(negedge clk);
      check("done_one_cycle", done, 0);

      // Start without a full image
      img_full = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_pulse", err_start, 1);
      check("err_busy", busy, 0);
      check("err_clear", clear_req, 0);
      check("err_valid", if8.out_valid, 0);
      @(negedge clk);
      check("err_one_cycle", err_start, 0);

      // Buffer changes mid-stream; start while busy is ignored
      img_z = '0;
      start8(img_z);
      @(negedge clk);
      run_stream(img_z, 1'b0, 0, 10, got);
      img_bits = '1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_start_err", err_start, 0);
      check("busy_start_idx", beat_idx, 10);
      run_stream(img_z, 1'b1, 10, -1, got);
      @(negedge clk);

      // Abort at beat 50, then a fresh stream from beat 0
      img_r = rand_img();
      start8(img_r);
      @(negedge clk);
      run_stream(img_r, 1'b1, 0, 50, got);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_valid", if8.out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_idx", beat_idx, 0);
      @(negedge clk);
      check("abort_no_done", done, 0);
      img_r = rand_img();
      start8(img_r);
      @(negedge clk);
      run_stream(img_r, 1'b0, 0, -1, got);
      @(negedge clk);

      // Abort during CAPTURE
      start8(rand_img());
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("cap_abort_valid", if8.out_valid, 0);
      check("cap_abort_busy", busy, 0);
      check("cap_abort_clear", clear_req, 0);
      @(negedge clk);
      check("cap_abort_done", done, 0);

      // Reset at beat 30
      img_r = rand_img();
      start8(img_r);
      @(negedge clk);
      run_stream(img_r, 1'b1, 0, 30, got);
      if8.out_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_valid", if8.out_valid, 0);
      check("mrst_busy", busy, 0);
      check("mrst_idx", beat_idx, 0);
      check("mrst_data", if8.out_data, 0);
      check("mrst_last", if8.out_last, 0);
      check("mrst_clear", clear_req, 0);
      @(negedge clk);
      check("mrst_no_done", done, 0);

      // WORD_W=16 instance, pixel 0 and 783 image
      img16 = img_a; full16 = 1'b1; start16 = 1'b1; if16.out_ready = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      check("w16_clear", clr16, 1);
      @(negedge clk);
      got = 0;
      for (int c = 0; c < 200 && got < BEATS16; c++) begin
         check("w16_valid", if16.out_valid, 1);
         check("w16_data", if16.out_data, beat_of(img_a, got, 16));
         check("w16_last", if16.out_last, (got == BEATS16 - 1));
         got++;
         @(negedge clk);
      end
      check("w16_count", got, BEATS16);
      check("w16_done", done16, 1);
      check("w16_busy", busy16, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
